// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master arbiter: state encoding, field widths,
// requester indices and the round-robin pick used at arbitration time.
package i2c_pkg;

   // Arbiter states; encoding is fixed so debug probes read the same everywhere.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StOwn   = 2'd1,
      StDrain = 2'd2,
      StForce = 2'd3
   } arb_state_e;

   // Width of the byte-count field, matches the master's N_Byte input.
   localparam int unsigned NBYTE_W = 6;

   // Requester indices into req/grant and the per-requester status vectors.
   localparam int unsigned REQ_REMOTE = 0;
   localparam int unsigned REQ_POLL   = 1;

   // One-hot winner for a non-empty request vector. On a tie the requester
   // that did not own the bus last time wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] req_vec,
                                          input logic       last_owner);
      logic [1:0] pick;
      if (req_vec == 2'b11) begin
         pick = last_owner ? 2'b01 : 2'b10;
      end else begin
         pick = req_vec;
      end
      return pick;
   endfunction

endpackage

// File: rtl/i2c_arb_watchdog.sv
// Stall watchdog for the arbiter: counts cycles while enabled, clears on
// request, saturates at TIMEOUT_CYCLES-1 and flags expiry while parked there.
module i2c_arb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter int unsigned TO_W           = 21
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   // Next count: clear wins, otherwise count up and hold at the last value.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != CntLast)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = en & ~clr & (cnt_q == CntLast);

endmodule

// File: rtl/i2c_master_arbiter.sv
// Two-requester arbiter in front of the single I2C master engine. A grant
// covers a whole transaction; only the owner's command fields reach the
// master and only the owner sees the master's status. A watchdog forces a
// STOP and revokes the grant if the owner stalls the bus.
module i2c_master_arbiter #(
   parameter int unsigned NBYTE_W        = i2c_pkg::NBYTE_W,
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter int unsigned TO_W           = 21
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req,
   output logic [1:0]         grant,
   input  logic               r0_go,
   input  logic               r1_go,
   input  logic               r0_stop,
   input  logic               r1_stop,
   input  logic               r0_rw,
   input  logic               r1_rw,
   input  logic [NBYTE_W-1:0] r0_nbyte,
   input  logic [NBYTE_W-1:0] r1_nbyte,
   input  logic [6:0]         r0_dev,
   input  logic [6:0]         r1_dev,
   input  logic [7:0]         r0_ptr,
   input  logic [7:0]         r1_ptr,
   input  logic [7:0]         r0_wdata,
   input  logic [7:0]         r1_wdata,
   output logic [1:0]         done_o,
   output logic [1:0]         ready_o,
   output logic [1:0]         ack_o,
   output logic [7:0]         rdata_o,
   output logic [1:0]         timeout_o,
   output logic               m_go,
   output logic               m_stop,
   output logic               m_rw,
   output logic [NBYTE_W-1:0] m_nbyte,
   output logic [6:0]         m_dev,
   output logic [7:0]         m_ptr,
   output logic [7:0]         m_wdata,
   input  logic               m_done,
   input  logic               m_ready,
   input  logic               m_ack,
   input  logic [7:0]         m_rdata
);

   import i2c_pkg::*;

   arb_state_e state_q;
   logic [1:0] grant_q;
   logic       last_owner_q;
   logic [1:0] timeout_q;

   logic       owner_req;
   logic       wd_clr;
   logic       wd_en;
   logic       wd_expire;

   // Owner still holding its request line.
   assign owner_req = |(req & grant_q);

   // Watchdog only runs while a transaction is in flight; every master done
   // pulse and every fresh grant restart the stall window.
   assign wd_en  = (state_q == StOwn);
   assign wd_clr = (state_q != StOwn) | m_done;

   i2c_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   // Arbitration FSM: grant, round-robin memory and the timeout pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         grant_q      <= 2'b00;
         last_owner_q <= 1'b1;
         timeout_q    <= 2'b00;
      end else begin
         timeout_q <= 2'b00;
         case (state_q)
            StIdle: begin
               // A busy master keeps the bus where it is.
               if (m_ready && (req != 2'b00)) begin
                  grant_q <= rr_pick(req, last_owner_q);
                  state_q <= StOwn;
               end
            end
            StOwn: begin
               if (!owner_req) begin
                  state_q <= StDrain;
               end else if (wd_expire) begin
                  state_q   <= StForce;
                  timeout_q <= grant_q;
               end
            end
            StDrain, StForce: begin
               // Release only once the master has finished its STOP.
               if (m_ready) begin
                  grant_q      <= 2'b00;
                  last_owner_q <= grant_q[REQ_POLL];
                  state_q      <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   // Command mux onto the master, driven from the registered grant so a
   // non-owner's strobes can never leak through.
   always_comb begin
      m_go    = 1'b0;
      m_stop  = 1'b0;
      m_rw    = 1'b0;
      m_nbyte = '0;
      m_dev   = '0;
      m_ptr   = '0;
      m_wdata = '0;

      if (grant_q[REQ_POLL]) begin
         m_rw    = r1_rw;
         m_nbyte = r1_nbyte;
         m_dev   = r1_dev;
         m_ptr   = r1_ptr;
         m_wdata = r1_wdata;
      end else if (grant_q[REQ_REMOTE]) begin
         m_rw    = r0_rw;
         m_nbyte = r0_nbyte;
         m_dev   = r0_dev;
         m_ptr   = r0_ptr;
         m_wdata = r0_wdata;
      end

      case (state_q)
         StOwn: begin
            m_go   = grant_q[REQ_POLL] ? r1_go   : r0_go;
            m_stop = grant_q[REQ_POLL] ? r1_stop : r0_stop;
         end
         StDrain, StForce: begin
            // Hold STOP asserted until the master reports ready.
            m_go   = 1'b0;
            m_stop = 1'b1;
         end
         default: begin
            m_go   = 1'b0;
            m_stop = 1'b0;
         end
      endcase
   end

   // Status routing: only the owner's bit follows the master.
   always_comb begin
      done_o  = grant_q & {2{m_done}};
      ready_o = grant_q & {2{m_ready}};
      ack_o   = grant_q & {2{m_ack}};
   end

   assign rdata_o   = m_rdata;
   assign grant     = grant_q;
   assign timeout_o = timeout_q;

   grant_onehot_a : assert property (@(posedge clk) disable iff (!reset) $onehot0(grant_q));

   grant_stable_busy_a : assert property (@(posedge clk) disable iff (!reset)
      !m_ready |=> $stable(grant_q));

   timeout_single_a : assert property (@(posedge clk) disable iff (!reset)
      (timeout_q != 2'b00) |=> (timeout_q == 2'b00));

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares the single I2C master engine between two requesters: requester 0 is the remote-RAM slave controller and requester 1 is a future poller.
- Grants exclusive ownership for a whole transaction.
- Muxes the granted requester's command fields onto the master and routes the master's status back to the owner only.
- Includes a watchdog that forces a STOP and releases a requester that stalls the bus.

Parameters:
- NBYTE_W, 6, width of byte-count field (matches master N_Byte)
- TIMEOUT_CYCLES, 2000000, clk cycles a grant may run without a master done pulse before forced release
- TO_W, 21, watchdog counter width (must hold TIMEOUT_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  2  per-requester bus request, held high for whole transaction
- grant  out  2  one-hot ownership (at most one bit set)
- r0_go, r1_go  in  1  start strobe from requester
- r0_stop, r1_stop  in  1  stop request from requester
- r0_rw, r1_rw  in  1  1=read, 0=write
- r0_nbyte, r1_nbyte  in  NBYTE_W  byte count
- r0_dev, r1_dev  in  7  slave address
- r0_ptr, r1_ptr  in  8  slave register pointer
- r0_wdata, r1_wdata  in  8  write data
- done_o, ready_o, ack_o  out  2  per-requester gated copies of master done/ready/ack_e
- rdata_o  out  8  master read data (valid for owner only)
- timeout_o  out  2  one-cycle pulse to requester whose grant was revoked
- m_go, m_stop, m_rw  out  1  to master
- m_nbyte  out  NBYTE_W  to master
- m_dev  out  7  to master
- m_ptr  out  8  to master
- m_wdata  out  8  to master
- m_done, m_ready, m_ack  in  1  from master
- m_rdata  in  8  from master

Behaviour:
- Reset (reset=0, async): state IDLE, grant=00, last_owner=1 (so r0 wins first tie), watchdog=0, all m_* outputs 0, done_o/ready_o/ack_o/timeout_o=00.
- States: IDLE, OWN, DRAIN, FORCE.
- IDLE: wait for m_ready=1 and req!=00.
  - Only one request: grant it.
  - Both request: grant the one that is not last_owner (round-robin).
  - grant registered, so it is visible the cycle after the request is sampled → OWN.
- OWN:
  - m_* outputs = owner's fields (combinational mux on registered grant).
  - done_o/ready_o/ack_o bit of owner = master signals; other bit forced 0.
  - rdata_o = m_rdata always.
  - Watchdog cleared on m_done=1 or on entry, else increments.
  - Owner req falls → DRAIN.
  - Watchdog reaches TIMEOUT_CYCLES-1 → FORCE.
- DRAIN:
  - m_go=0, m_stop=owner's stop ORed with 1 (stop held).
  - Stay until m_ready=1, then grant=00, last_owner=owner → IDLE.
  - Minimum one cycle in DRAIN.
- FORCE:
  - m_go=0, m_stop=1, timeout_o[owner]=1 for the first cycle only.
  - Wait m_ready=1 → grant=00, last_owner=owner → IDLE.
  - A requester that still holds req after timeout is eligible again only via normal round-robin.
- Non-owner go/stop are ignored entirely; they never reach the master.
- Grant never changes while the master is busy (m_ready=0).
- The same-cycle request of the other requester while DRAIN completes is serviced from IDLE on the next cycle; there is no back-to-back grant without passing IDLE.
- req dropped and re-raised by owner inside DRAIN: not re-granted until IDLE arbitration.
- Watchdog saturates; no wrap-around.
- Reset mid-transaction: m_go/m_stop drop immediately (async); master recovery is the master's own reset.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding (IDLE=2'd0, OWN=2'd1, DRAIN=2'd2, FORCE=2'd3);
  - NBYTE_W;
  - requester index constants REQ_REMOTE=0, REQ_POLL=1.
- One sub-module natural: i2c_arb_watchdog, a TO_W counter with clear/enable/expire pulse.
- Mux and routing stay in the top.

Test Plan:
- Single request: req=01, m_ready=1 → grant=01 next cycle; r0 fields (dev=7'h22, ptr=8'h05, nbyte=3) appear on m_*; r1_go pulses never reach m_go.
- Contention after reset: req=11 → grant=01. Drop req[0], m_ready=1 → IDLE then grant=10. Repeat req=11 → grant=01 (round-robin alternation).
- Busy master: req=01 with m_ready=0 → grant stays 00 until m_ready rises, then grant=01 one cycle later.
- Gating: owner r1, m_done pulse and m_ack=1 → done_o=10, ack_o=10; done_o[0] stays 0.
- Timeout (TIMEOUT_CYCLES=16 in bench): grant r0, no m_done for 16 cycles → m_stop=1, timeout_o=01 single pulse; after m_ready=1 → grant=00.
- Async reset asserted during OWN → grant=00 and m_go=0 without waiting for a clk edge; after release, first tie goes to r0.
